// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S transmitter.
// Shared by audio_lock_sync and audio_i2s_tx.
package audio_pkg;

    typedef enum logic [1:0] {
        StWaitLock,
        StSettle,
        StRun
    } state_e;

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_BITS  = 32;

    function automatic int unsigned settle_cnt_w(int unsigned lock_wait);
        return $clog2(lock_wait + 1);
    endfunction

endpackage

// File: rtl/audio_lock_sync.sv
// PLL lock synchronizer and settle timer.
// settled is high once count_en has been held for LOCK_WAIT cycles.
module audio_lock_sync import audio_pkg::*; #(
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic count_en,
    output logic lock_s,
    output logic settled
);

    localparam int unsigned CNT_W = settle_cnt_w(LOCK_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

    logic             lock_meta;
    logic [CNT_W-1:0] settle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            settle_cnt <= '0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            if (!count_en) begin
                settle_cnt <= '0;
            end else if (!settled) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end
        end
    end

    // Compare against LOCK_WAIT-1 so the FSM spends exactly LOCK_WAIT cycles in SETTLE.
    assign settled = (settle_cnt == CNT_LAST);

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: BCLK/LRCK generation and stereo serialization, gated by PLL lock.
// Optional AUDIO_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_i2s_tx import audio_pkg::*; #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned BCLK_DIV  = 4,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_dacdat,
    output logic              running,
    output logic              underrun
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int unsigned DIV_W     = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W     = $clog2(FRAME_BITS);
    localparam int unsigned POS_W     = $clog2(SLOT_BITS);
    localparam int unsigned POS_MAX_W = POS_W + 1;

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [POS_MAX_W-1:0] POS_MAX  = POS_MAX_W'(DATA_W);

    state_e            state;
    logic              lock_s;
    logic              settled;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bitcnt;
    logic [BIT_W-1:0]  bitcnt_next;
    logic [POS_W-1:0]  pos;
    logic              fall;
    logic              frame_start;
    logic              in_slot;
    logic              xfer;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] sh_l;
    logic [DATA_W-1:0] sh_r;

    audio_lock_sync #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_sync (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .count_en   (state == StSettle),
        .lock_s     (lock_s),
        .settled    (settled)
    );

    always_comb begin
        fall        = (div == DIV_LAST);
        div_next    = fall ? '0 : div + DIV_W'(1);
        bitcnt_next = bitcnt + BIT_W'(1);
        pos         = bitcnt_next[POS_W-1:0];
        in_slot     = (pos != '0) && ({1'b0, pos} <= POS_MAX);
        frame_start = fall && (bitcnt == BIT_LAST);
        xfer        = s_valid && s_ready;
    end

    assign s_ready = running && !hold_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StWaitLock;
            running    <= 1'b0;
            underrun   <= 1'b0;
            div        <= '0;
            bitcnt     <= '0;
            i2s_bclk   <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_dacdat <= 1'b0;
            hold_valid <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            sh_l       <= '0;
            sh_r       <= '0;
        end else begin
            underrun <= 1'b0;

            case (state)
                StWaitLock: begin
                    if (lock_s) state <= StSettle;
                end
                StSettle: begin
                    if (!lock_s) begin
                        state <= StWaitLock;
                    end else if (settled) begin
                        state   <= StRun;
                        running <= 1'b1;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state   <= StWaitLock;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= StWaitLock;
                    running <= 1'b0;
                end
            endcase

            if (state == StRun && lock_s) begin
                div      <= div_next;
                i2s_bclk <= (div_next >= DIV_HALF);
                if (fall) begin
                    bitcnt     <= bitcnt_next;
                    i2s_lrck   <= bitcnt_next[BIT_W-1];
                    i2s_dacdat <= 1'b0;
                    if (frame_start) begin
                        if (hold_valid) begin
                            sh_l       <= hold_l;
                            sh_r       <= hold_r;
                            hold_valid <= 1'b0;
                        end else begin
                            sh_l     <= '0;
                            sh_r     <= '0;
                            underrun <= 1'b1;
                        end
                    end else if (in_slot) begin
                        if (bitcnt_next[BIT_W-1]) begin
                            i2s_dacdat <= sh_r[DATA_W-1];
                            sh_r       <= sh_r << 1;
                        end else begin
                            i2s_dacdat <= sh_l[DATA_W-1];
                            sh_l       <= sh_l << 1;
                        end
                    end
                end
                // Only possible while holding is empty, so it never collides with the load above.
                if (xfer) begin
                    hold_l     <= s_left;
                    hold_r     <= s_right;
                    hold_valid <= 1'b1;
                end
            end else begin
                // Entry into RUN also passes through here, so the first frame plays zeros.
                div        <= '0;
                bitcnt     <= '0;
                i2s_bclk   <= 1'b0;
                i2s_lrck   <= 1'b0;
                i2s_dacdat <= 1'b0;
                hold_valid <= 1'b0;
                hold_l     <= '0;
                hold_r     <= '0;
                sh_l       <= '0;
                sh_r       <= '0;
            end
        end
    end

`ifdef AUDIO_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: bring-up, per-frame serialization table, lock loss,
// async reset, settle glitch. Covers underrun_count when AUDIO_UNDERRUN_CNT_EN is defined.
module tb_audio_i2s_tx;

    localparam int DATA_W = 24;
    localparam int NFR    = 11;
    localparam int FRAME  = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pll_locked = 1'b0;
    logic [DATA_W-1:0] s_left = '0;
    logic [DATA_W-1:0] s_right = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              i2s_bclk;
    logic              i2s_lrck;
    logic              i2s_dacdat;
    logic              running;
    logic              underrun;
`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [15:0]       underrun_count;
`endif

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .DATA_W    (DATA_W),
        .BCLK_DIV  (4),
        .LOCK_WAIT (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .s_left         (s_left),
        .s_right        (s_right),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .i2s_bclk       (i2s_bclk),
        .i2s_lrck       (i2s_lrck),
        .i2s_dacdat     (i2s_dacdat),
        .running        (running),
        .underrun       (underrun)
`ifdef AUDIO_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    // offset: cycle within the preceding frame at which the pair is first offered (-1 = never)
    typedef struct {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        int                offset;
        logic              exp_ur;
    } frame_vec_t;

    frame_vec_t vec [NFR];
    int passed = 0;
    int total  = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
        else passed++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        else passed++;
    endtask

    // Counts negedges until running rises (bounded); also counts nonzero idle outputs meanwhile.
    task automatic wait_running(output int cyc, output int busy);
        cyc  = 0;
        busy = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (running) break;
            busy += int'(i2s_bclk) + int'(i2s_lrck) + int'(i2s_dacdat) + int'(s_ready)
                  + int'(underrun);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int                cyc;
        int                busy;
        logic [DATA_W-1:0] cur_l, cur_r, m_hold_l, m_hold_r, word;
        logic              m_full;
        logic              taken [NFR];
        int                e_dat, e_clk, e_rdy, ur_seen;

        vec[0]  = '{24'h000000, 24'h000000, -1,  1'b0};
        vec[1]  = '{24'hA5A5A5, 24'h5A5A5A, 0,   1'b0};
        vec[2]  = '{24'h123456, 24'hABCDEF, 10,  1'b0};
        vec[3]  = '{24'h000000, 24'h000000, -1,  1'b1};
        vec[4]  = '{24'h800000, 24'h7FFFFF, 0,   1'b0};
        vec[5]  = '{24'hC3C3C3, 24'h3C3C3C, 255, 1'b1};
        vec[6]  = '{24'h000000, 24'h000000, -1,  1'b0};
        vec[7]  = '{24'h000001, 24'hFFFFFF, 3,   1'b0};
        vec[8]  = '{24'h000010, 24'h000011, 0,   1'b0};
        vec[9]  = '{24'h000012, 24'h000013, 0,   1'b0};
        vec[10] = '{24'h000014, 24'h000015, 0,   1'b0};

        repeat (3) @(negedge clk);
        check_bit("reset bclk", i2s_bclk, 1'b0);
        check_bit("reset lrck", i2s_lrck, 1'b0);
        check_bit("reset dacdat", i2s_dacdat, 1'b0);
        check_bit("reset s_ready", s_ready, 1'b0);
        check_bit("reset running", running, 1'b0);
        check_bit("reset underrun", underrun, 1'b0);

        rst = 1'b0;
        repeat (10) @(negedge clk);
        pll_locked = 1'b1;
        wait_running(cyc, busy);
        check_range("bring-up latency", cyc, 1026, 1028);
        check_int("idle outputs before run", busy, 0);

        // Main table: now at negedge n=0, first cycle of RUN.
        cur_l = '0; cur_r = '0; m_hold_l = '0; m_hold_r = '0; m_full = 1'b0;
        foreach (taken[i]) taken[i] = 1'b0;
        e_dat = 0; e_clk = 0; e_rdy = 0; ur_seen = 0;
        for (int n = 0; n < NFR * FRAME; n++) begin
            int   fr, ph, b, p, nf;
            logic e_bclk, e_lrck, e_d, offer;
            if (n != 0) @(negedge clk);
            fr = n / FRAME;
            ph = n % FRAME;
            b  = (n / 4) % 64;
            p  = b % 32;
            e_bclk = ((n % 4) >= 2);
            e_lrck = (b >= 32);
            word   = e_lrck ? cur_r : cur_l;
            e_d    = (p >= 1 && p <= DATA_W) ? word[DATA_W-p] : 1'b0;
            if (i2s_dacdat !== e_d) e_dat++;
            if (i2s_bclk !== e_bclk || i2s_lrck !== e_lrck || running !== 1'b1) e_clk++;
            if (s_ready !== !m_full) e_rdy++;
            if (underrun === 1'b1) ur_seen++;
            if (ph == FRAME - 1) begin
                check_int($sformatf("frame %0d dacdat errors", fr), e_dat, 0);
                check_int($sformatf("frame %0d bclk/lrck errors", fr), e_clk, 0);
                check_int($sformatf("frame %0d s_ready errors", fr), e_rdy, 0);
                check_int($sformatf("frame %0d underrun pulses", fr), ur_seen, int'(vec[fr].exp_ur));
                e_dat = 0; e_clk = 0; e_rdy = 0; ur_seen = 0;
            end
            // Drive the pair for the next frame and advance the model across the coming edge.
            nf    = fr + 1;
            offer = 1'b0;
            if (nf < NFR) offer = (vec[nf].offset >= 0) && (ph >= vec[nf].offset) && !taken[nf];
            s_valid = offer;
            s_left  = (nf < NFR) ? vec[nf].left : '0;
            s_right = (nf < NFR) ? vec[nf].right : '0;
            if (offer && !m_full) begin
                if ((n + 1) % FRAME == 0) begin
                    cur_l = '0; cur_r = '0;
                end
                m_hold_l = vec[nf].left; m_hold_r = vec[nf].right; m_full = 1'b1; taken[nf] = 1'b1;
            end else if ((n + 1) % FRAME == 0) begin
                if (m_full) begin
                    cur_l = m_hold_l; cur_r = m_hold_r; m_full = 1'b0;
                end else begin
                    cur_l = '0; cur_r = '0;
                end
            end
        end
        s_valid = 1'b0;

`ifdef AUDIO_UNDERRUN_CNT_EN
        check_int("underrun_count", int'(underrun_count), 2);
`endif

        // Lock loss at bitcnt 40 of frame 11.
        repeat (161) @(negedge clk);
        check_bit("lrck at bitcnt 40", i2s_lrck, 1'b1);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("lock loss running", running, 1'b0);
        check_bit("lock loss bclk", i2s_bclk, 1'b0);
        check_bit("lock loss lrck", i2s_lrck, 1'b0);
        check_bit("lock loss dacdat", i2s_dacdat, 1'b0);
        check_bit("lock loss s_ready", s_ready, 1'b0);

        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        wait_running(cyc, busy);
        check_range("relock latency", cyc, 1026, 1028);

        // Asynchronous reset while bclk is high.
        repeat (50) @(negedge clk);
        check_bit("bclk high before reset", i2s_bclk, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("async reset running", running, 1'b0);
        check_bit("async reset bclk", i2s_bclk, 1'b0);
        check_bit("async reset s_ready", s_ready, 1'b0);
        check_bit("async reset lrck", i2s_lrck, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Settle glitch: drop lock ~500 cycles into SETTLE for 5 cycles.
        repeat (503) @(negedge clk);
        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        check_bit("glitch running", running, 1'b0);
        pll_locked = 1'b1;
        wait_running(cyc, busy);
        check_range("post-glitch latency", cyc, 1026, 1028);
        check_int("idle outputs during glitch settle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
